// File: rtl/hs32_alu_sched_if.sv
// Request/response bundle for the two-port hs32 ALU scheduler.
// The master is the requester side; the slave is the scheduler.
interface hs32_alu_sched_if;
  logic        r0_valid_i;
  logic        r0_ready_o;
  logic [31:0] r0_a_i;
  logic [31:0] r0_b_i;
  logic [3:0]  r0_op_i;
  logic        r0_flwe_i;
  logic        r0_done_o;
  logic [31:0] r0_res_o;
  logic [3:0]  r0_fl_o;
  logic        r0_ack_i;

  logic        r1_valid_i;
  logic        r1_ready_o;
  logic [31:0] r1_a_i;
  logic [31:0] r1_b_i;
  logic [3:0]  r1_op_i;
  logic        r1_done_o;
  logic [31:0] r1_res_o;
  logic [3:0]  r1_fl_o;
  logic        r1_ack_i;

  logic        fl_we_i;
  logic [3:0]  fl_wdata_i;
  logic [3:0]  flags_o;
  logic [15:0] conflict_o;

  modport master (
    output r0_valid_i, r0_a_i, r0_b_i, r0_op_i, r0_flwe_i, r0_ack_i,
    output r1_valid_i, r1_a_i, r1_b_i, r1_op_i, r1_ack_i,
    output fl_we_i, fl_wdata_i,
    input  r0_ready_o, r0_done_o, r0_res_o, r0_fl_o,
    input  r1_ready_o, r1_done_o, r1_res_o, r1_fl_o,
    input  flags_o, conflict_o
  );

  modport slave (
    input  r0_valid_i, r0_a_i, r0_b_i, r0_op_i, r0_flwe_i, r0_ack_i,
    input  r1_valid_i, r1_a_i, r1_b_i, r1_op_i, r1_ack_i,
    input  fl_we_i, fl_wdata_i,
    output r0_ready_o, r0_done_o, r0_res_o, r0_fl_o,
    output r1_ready_o, r1_done_o, r1_res_o, r1_fl_o,
    output flags_o, conflict_o
  );
endinterface

// File: rtl/hs32_alu_sched.sv
// Round-robin scheduler sharing one ALU between two requesters; owns the NZCV flags
// register and returns one registered response per accepted request.
module hs32_alu_sched #(
  parameter logic [3:0] FL_INIT = 4'b0000
) (
  input logic              clk,
  input logic              reset,
  hs32_alu_sched_if.slave  bus
);
  localparam logic [3:0] HS32A_ADD = 4'h0;
  localparam logic [3:0] HS32A_SUB = 4'h1;

  logic        r_done0, r_done1, r_last;
  logic [31:0] r_res0, r_res1;
  logic [3:0]  r_fl0, r_fl1, r_flags;
  logic [15:0] r_conflict;

  logic        w_elig0, w_elig1, w_gnt0, w_gnt1, w_carry;
  logic [31:0] w_a, w_b, w_res;
  logic [3:0]  w_op, w_fl;
  logic [32:0] w_wide;

  // r_last = 1 means port 1 was granted most recently, so port 0 wins a tie.
  always_comb begin
    w_elig0 = bus.r0_valid_i && (!r_done0 || bus.r0_ack_i);
    w_elig1 = bus.r1_valid_i && (!r_done1 || bus.r1_ack_i);
    w_gnt0  = !reset && w_elig0 && (!w_elig1 || r_last);
    w_gnt1  = !reset && w_elig1 && (!w_elig0 || !r_last);
  end

  always_comb begin
    w_a     = w_gnt1 ? bus.r1_a_i  : bus.r0_a_i;
    w_b     = w_gnt1 ? bus.r1_b_i  : bus.r0_b_i;
    w_op    = w_gnt1 ? bus.r1_op_i : bus.r0_op_i;
    w_wide  = '0;
    w_res   = w_b;
    w_carry = r_flags[1];
    case (w_op)
      HS32A_ADD: begin
        w_wide  = {1'b0, w_a} + {1'b0, w_b};
        w_res   = w_wide[31:0];
        w_carry = w_wide[32];
      end
      HS32A_SUB: begin
        w_wide  = {1'b0, w_a} - {1'b0, w_b};
        w_res   = w_wide[31:0];
        w_carry = w_wide[32];
      end
      default: ;
    endcase
    w_fl = {(w_op == HS32A_SUB) && w_res[31], w_res == 32'd0, w_carry, !w_carry && w_res[31]};
  end

  assign bus.r0_ready_o = w_gnt0;
  assign bus.r1_ready_o = w_gnt1;
  assign bus.r0_done_o  = r_done0;
  assign bus.r1_done_o  = r_done1;
  assign bus.r0_res_o   = r_res0;
  assign bus.r1_res_o   = r_res1;
  assign bus.r0_fl_o    = r_fl0;
  assign bus.r1_fl_o    = r_fl1;
  assign bus.flags_o    = r_flags;
  assign bus.conflict_o = r_conflict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_res0     <= '0;
      r_res1     <= '0;
      r_fl0      <= '0;
      r_fl1      <= '0;
      r_flags    <= FL_INIT;
      r_last     <= 1'b1;
      r_conflict <= '0;
    end else begin
      if (w_gnt0) begin
        r_done0 <= 1'b1;
        r_res0  <= w_res;
        r_fl0   <= w_fl;
      end else if (bus.r0_ack_i) begin
        r_done0 <= 1'b0;
      end
      if (w_gnt1) begin
        r_done1 <= 1'b1;
        r_res1  <= w_res;
        r_fl1   <= w_fl;
      end else if (bus.r1_ack_i) begin
        r_done1 <= 1'b0;
      end
      if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
      // External restore beats an in-flight port 0 flag write.
      if (bus.fl_we_i) begin
        r_flags <= bus.fl_wdata_i;
      end else if (w_gnt0 && bus.r0_flwe_i) begin
        r_flags <= w_fl;
      end
      if (w_elig0 && w_elig1 && (r_conflict != 16'hFFFF)) r_conflict <= r_conflict + 16'd1;
    end
  end
endmodule

// File: tb/tb_hs32_alu_sched.sv
// Directed plus randomized bench for hs32_alu_sched against a behavioural model.
module tb_hs32_alu_sched;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] FL_INIT = 4'b0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hs32_alu_sched_if bus ();

  hs32_alu_sched #(.FL_INIT(FL_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_done[2];
  logic [31:0] m_res[2];
  logic [3:0]  m_fl[2];
  logic [3:0]  m_flags;
  int          m_prev;
  int          m_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {result, NZCV} from the arithmetic rules.
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl);
    logic [31:0] r;
    bit c;
    bit n;
    if (op == OP_ADD) begin
      r = a + b;
      c = (longint'(a) + longint'(b)) > 64'hFFFF_FFFF;
    end else if (op == OP_SUB) begin
      r = a - b;
      c = a < b;
    end else begin
      r = b;
      c = fl[1];
    end
    n = (op == OP_SUB) ? r[31] : 1'b0;
    return {r, n, r == 32'd0, c, !c && r[31]};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_done[p] = 1'b0;
      m_res[p]  = '0;
      m_fl[p]   = '0;
    end
    m_flags = FL_INIT;
    m_prev  = 1;
    m_conf  = 0;
  endtask

  task automatic drive(input int p, input bit v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit flwe, input bit ack);
    if (p == 0) begin
      bus.r0_valid_i = v; bus.r0_op_i = op; bus.r0_a_i = a; bus.r0_b_i = b;
      bus.r0_flwe_i = flwe; bus.r0_ack_i = ack;
    end else begin
      bus.r1_valid_i = v; bus.r1_op_i = op; bus.r1_a_i = a; bus.r1_b_i = b;
      bus.r1_ack_i = ack;
    end
  endtask

  // Called just after a falling edge with inputs applied; ends at the next falling edge.
  task automatic cycle(input bit do_chk);
    bit v[2], k[2], e[2];
    logic [31:0] a[2], b[2];
    logic [3:0] op[2];
    logic [35:0] out;
    int win;
    #1;
    v[0] = bus.r0_valid_i; v[1] = bus.r1_valid_i;
    k[0] = bus.r0_ack_i;   k[1] = bus.r1_ack_i;
    a[0] = bus.r0_a_i;     a[1] = bus.r1_a_i;
    b[0] = bus.r0_b_i;     b[1] = bus.r1_b_i;
    op[0] = bus.r0_op_i;   op[1] = bus.r1_op_i;
    for (int p = 0; p < 2; p++) e[p] = v[p] && (!m_done[p] || k[p]);
    if (e[0] && e[1]) win = 1 - m_prev;
    else if (e[0]) win = 0;
    else if (e[1]) win = 1;
    else win = -1;
    if (do_chk) begin
      chk("ready0", 32'(bus.r0_ready_o), 32'(win == 0));
      chk("ready1", 32'(bus.r1_ready_o), 32'(win == 1));
    end
    out = (win >= 0) ? alu_ref(op[win], a[win], b[win], m_flags) : '0;
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (win == p) begin
        m_done[p] = 1'b1;
        m_res[p]  = out[35:4];
        m_fl[p]   = out[3:0];
      end else if (k[p]) begin
        m_done[p] = 1'b0;
      end
    end
    if (bus.fl_we_i) m_flags = bus.fl_wdata_i;
    else if (win == 0 && bus.r0_flwe_i) m_flags = out[3:0];
    if (e[0] && e[1] && m_conf < 65535) m_conf++;
    if (win >= 0) m_prev = win;
    #1;
    if (do_chk) begin
      chk("done0", 32'(bus.r0_done_o), 32'(m_done[0]));
      chk("done1", 32'(bus.r1_done_o), 32'(m_done[1]));
      chk("res0", bus.r0_res_o, m_res[0]);
      chk("res1", bus.r1_res_o, m_res[1]);
      chk("fl0", 32'(bus.r0_fl_o), 32'(m_fl[0]));
      chk("fl1", 32'(bus.r1_fl_o), 32'(m_fl[1]));
      chk("flags", 32'(bus.flags_o), 32'(m_flags));
      chk("conflict", 32'(bus.conflict_o), 32'(m_conf));
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, OP_ADD, 0, 0, 0, 0);
    drive(1, 0, OP_ADD, 0, 0, 0, 0);
    bus.fl_we_i = 1'b0;
    bus.fl_wdata_i = 4'h0;
    model_reset();
    #12;
    chk("rst_done0", 32'(bus.r0_done_o), 32'd0);
    chk("rst_done1", 32'(bus.r1_done_o), 32'd0);
    chk("rst_flags", 32'(bus.flags_o), 32'(FL_INIT));
    chk("rst_conflict", 32'(bus.conflict_o), 32'd0);
    chk("rst_res0", bus.r0_res_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD overflowing to zero, flags written
    drive(0, 1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1, 0);
    cycle(1);
    chk("add_fl", 32'(bus.r0_fl_o), 32'h6);
    chk("add_flags", 32'(bus.flags_o), 32'h6);
    drive(0, 0, OP_ADD, 0, 0, 0, 1);
    cycle(1);

    // SUB with borrow on port 1
    drive(0, 0, OP_ADD, 0, 0, 0, 0);
    drive(1, 1, OP_SUB, 32'd5, 32'd7, 0, 0);
    cycle(1);
    chk("sub_res", bus.r1_res_o, 32'hFFFF_FFFE);
    chk("sub_fl", 32'(bus.r1_fl_o), 32'hA);
    drive(1, 0, OP_ADD, 0, 0, 0, 1);
    cycle(1);

    // Ties with ack every cycle: grants alternate
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 4'($urandom_range(0, 2)), $urandom, $urandom, 1, 1);
      drive(1, 1, 4'($urandom_range(0, 2)), $urandom, $urandom, 0, 1);
      cycle(1);
    end
    drive(0, 0, OP_ADD, 0, 0, 0, 1);
    drive(1, 0, OP_ADD, 0, 0, 0, 1);
    cycle(1);

    // Pass-through keeps carry
    bus.fl_we_i = 1'b1; bus.fl_wdata_i = 4'b0010;
    cycle(1);
    bus.fl_we_i = 1'b0;
    drive(0, 1, OP_MOV, 32'h1234, 32'h8000_0000, 1, 0);
    cycle(1);
    chk("mov_res", bus.r0_res_o, 32'h8000_0000);
    chk("mov_fl", 32'(bus.r0_fl_o), 32'h2);

    // Backpressure on port 0 while port 1 is served
    drive(0, 1, OP_ADD, 32'd3, 32'd4, 0, 0);
    drive(1, 1, OP_SUB, 32'd9, 32'd2, 0, 1);
    cycle(1);
    cycle(1);
    chk("bp_hold", bus.r0_res_o, 32'h8000_0000);
    drive(0, 1, OP_ADD, 32'd3, 32'd4, 0, 1);
    drive(1, 0, OP_ADD, 0, 0, 0, 1);
    cycle(1);
    chk("bp_new", bus.r0_res_o, 32'd7);

    // External flags write beats port 0 flag write
    bus.fl_we_i = 1'b1; bus.fl_wdata_i = 4'hF;
    drive(0, 1, OP_ADD, 32'd1, 32'd1, 1, 1);
    cycle(1);
    chk("coll_flags", 32'(bus.flags_o), 32'hF);
    chk("coll_fl", 32'(bus.r0_fl_o), 32'h0);
    bus.fl_we_i = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(0, 1'($urandom), 4'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom),
            1'($urandom));
      drive(1, 1'($urandom), 4'($urandom_range(0, 3)), $urandom, $urandom, 0, 1'($urandom));
      bus.fl_we_i = ($urandom_range(0, 7) == 0);
      bus.fl_wdata_i = 4'($urandom);
      cycle(1);
    end
    bus.fl_we_i = 1'b0;

    // Asynchronous reset mid-operation
    drive(0, 1, OP_ADD, 32'd1, 32'd2, 1, 0);
    drive(1, 1, OP_ADD, 32'd3, 32'd4, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mrst_done0", 32'(bus.r0_done_o), 32'd0);
    chk("mrst_done1", 32'(bus.r1_done_o), 32'd0);
    chk("mrst_flags", 32'(bus.flags_o), 32'(FL_INIT));
    chk("mrst_ready0", 32'(bus.r0_ready_o), 32'd0);
    chk("mrst_ready1", 32'(bus.r1_ready_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, OP_ADD, 0, 0, 0, 0);
    drive(1, 0, OP_ADD, 0, 0, 0, 0);
    cycle(1);

    // Conflict counter saturation
    drive(0, 1, OP_ADD, 32'd1, 32'd1, 0, 1);
    drive(1, 1, OP_ADD, 32'd2, 32'd2, 0, 1);
    for (int i = 0; i < 65540; i++) cycle(0);
    cycle(1);
    chk("sat_conflict", 32'(bus.conflict_o), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
